// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO and its memory.
// Pointer width includes one extra wrap bit above the address bits.
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DATA_WIDTH x DEPTH dual-port storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with optional first-word-fall-through, almost thresholds,
// live fill count, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ptr_w(DEPTH)-1:0] count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and at least 4");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must be within 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must be within 0..DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         count_q;
    fifo_err_t             err_q;
    fifo_err_t             err_set;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Handshake: a write is taken on any edge where w_en=1 and full=0, a read
    // on any edge where r_en=1 and empty=0; a request against full/empty is
    // dropped and latched as an error. flush wins over both and sets nothing.
    assign wr_acc = w_en & ~full  & ~flush;
    assign rd_acc = r_en & ~empty & ~flush;

    assign err_set.overflow  = w_en & full  & ~flush;
    assign err_set.underflow = r_en & empty & ~flush;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign count        = count_q;
    assign almost_full  = (count_q >= PW'(AF_LEVEL));
    assign almost_empty = (count_q <= PW'(AE_LEVEL));
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + PW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - PW'(1);
            end
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q.overflow  <= err_set.overflow  | (err_q.overflow  & ~clr_err);
            err_q.underflow <= err_set.underflow | (err_q.underflow & ~clr_err);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        assign data_out = mem_rdata;
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= mem_rdata;
            end
        end

        assign data_out = data_q;
    end

endmodule
